// File: rtl/scaler_stream_tx.sv
// Head-of-pipeline pixel transmitter: buffers upstream pixels in a small FIFO and
// emits them as de/hs/vs strobes at a sparse pixel rate with inter-line blanking.
module scaler_stream_tx #(
  parameter int PIXEL_WIDTH   = 12,
  parameter int SPARSE_OUTPUT = 2,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            frame_width,
  input  logic [15:0]            frame_height,
  input  logic [15:0]            line_blank,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;
  localparam logic [GW-1:0] GAP_OPEN = GW'(SPARSE_OUTPUT);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIXEL,
    ST_BLANK,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [15:0] w_q, w_d, h_q, h_d, lb_q, lb_d;
  logic [15:0] col_q, col_d, row_q, row_d, blank_q, blank_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, done_q, done_d;

  logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, wvis_q;
  logic s_ready_q, s_ready_d;
  logic push, pop, empty;
  logic [PIXEL_WIDTH-1:0] rd_data;

  // The read side sees writes one cycle late (wvis_q), giving the two-cycle write-to-emit latency.
  assign push    = s_valid && s_ready_q;
  assign empty   = (wvis_q == rptr_q);
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d    = wptr_q + {{AW{1'b0}}, push};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    s_ready_d = !((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= s_data;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    lb_d    = lb_q;
    col_d   = col_q;
    row_d   = row_q;
    blank_d = blank_q;
    gap_d   = gap_q;
    do_d    = do_q;
    de_d    = 1'b0;
    hs_d    = 1'b0;
    vs_d    = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_d     = frame_width;
        h_d     = frame_height;
        lb_d    = line_blank;
        col_d   = '0;
        row_d   = '0;
        blank_d = '0;
        gap_d   = GAP_OPEN;
        if ((frame_width != 16'd0) && (frame_height != 16'd0)) begin
          state_d = ST_PIXEL;
        end
      end

      ST_PIXEL: begin
        if (gap_q == GAP_OPEN) begin
          if (!empty) begin
            pop   = 1'b1;
            do_d  = rd_data;
            de_d  = 1'b1;
            hs_d  = (col_q == 16'd0);
            vs_d  = (col_q == 16'd0) && (row_q == 16'd0);
            gap_d = '0;
            if (col_q == (w_q - 16'd1)) begin
              col_d = '0;
              if (lb_q != 16'd0) begin
                blank_d = '0;
                state_d = ST_BLANK;
              end else if (row_q == (h_q - 16'd1)) begin
                state_d = ST_DONE;
              end else begin
                // No blanking: next line continues at the sparse rate.
                row_d = row_q + 16'd1;
              end
            end else begin
              col_d = col_q + 16'd1;
            end
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      ST_BLANK: begin
        if (blank_q == (lb_q - 16'd1)) begin
          blank_d = '0;
          if (row_q == (h_q - 16'd1)) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 16'd1;
            gap_d   = GAP_OPEN;
            state_d = ST_PIXEL;
          end
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      lb_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      blank_q   <= '0;
      gap_q     <= '0;
      do_q      <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      done_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wvis_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      lb_q      <= lb_d;
      col_q     <= col_d;
      row_q     <= row_d;
      blank_q   <= blank_d;
      gap_q     <= gap_d;
      do_q      <= do_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      done_q    <= done_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      wvis_q    <= wptr_q;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign do_o       = do_q;
  assign de_o       = de_q;
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_scaler_stream_tx.sv
// Directed bench for scaler_stream_tx: sparse 2-gap instance plus a back-to-back instance.
module tb_scaler_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fw, fh, lb;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] do_o;
  logic        de_o, hs_o, vs_o, frame_done;

  logic [15:0] fw0, fh0, lb0;
  logic [11:0] s_data0;
  logic        s_valid0;
  logic        s_ready0;
  logic [11:0] do0;
  logic        de0, hs0, vs0, done0;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] wdata;

  scaler_stream_tx #(.PIXEL_WIDTH(12), .SPARSE_OUTPUT(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_width(fw), .frame_height(fh), .line_blank(lb),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .frame_done(frame_done)
  );

  scaler_stream_tx #(.PIXEL_WIDTH(12), .SPARSE_OUTPUT(0), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .frame_width(fw0), .frame_height(fh0), .line_blank(lb0),
    .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0), .frame_done(done0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the upstream counter moves on only when the word was accepted.
  task automatic step();
    logic acc;
    acc = s_valid && s_ready;
    @(negedge clk);
    if (acc) wdata = wdata + 12'd1;
    s_data = wdata;
  endtask

  initial begin
    int  pix;
    int  got;
    bit  seen_done;
    bit  expd;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; wdata = '0;
    fw = 16'd4; fh = 16'd0; lb = 16'd3;
    fw0 = 16'd3; fh0 = 16'd0; lb0 = 16'd0; s_valid0 = 1'b0; s_data0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_do", do_o, 0);
    chk("rst_de", de_o, 0);
    chk("rst_hs", hs_o, 0);
    chk("rst_vs", vs_o, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", s_ready, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", s_ready, 1);

    // 4x2 frame, blank 3, FIFO prefilled with 1..8
    wdata = 12'd1; s_data = wdata; s_valid = 1'b1;
    repeat (8) begin step(); chk("t1_fill_no_de", de_o, 0); end
    s_valid = 1'b0;
    fh = 16'd2;
    step();
    chk("t1_start_no_de", de_o, 0);
    fh = 16'd0;
    pix = 0;
    for (int k = 0; k < 28; k++) begin
      step();
      expd = k inside {0, 3, 6, 9, 13, 16, 19, 22};
      chk("t1_de", de_o, expd);
      if (expd) begin
        pix++;
        chk("t1_data", do_o, pix);
        chk("t1_hs", hs_o, (pix == 1) || (pix == 5));
        chk("t1_vs", vs_o, pix == 1);
      end
      chk("t1_done", frame_done, k == 26);
    end

    // Upstream stall of 10 cycles before pixel 3
    wdata = 12'h21; s_data = wdata; s_valid = 1'b1;
    step(); step();
    s_valid = 1'b0;
    fh = 16'd2;
    step();
    fh = 16'd0;
    for (int k = 0; k < 14; k++) begin
      step();
      chk("t2_de", de_o, (k == 0) || (k == 3));
      if (k == 0) chk("t2_p1", do_o, 32'h21);
      if (k == 3) chk("t2_p2", do_o, 32'h22);
    end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("t2_lat1", de_o, 0);
    step();
    chk("t2_lat2", de_o, 0);
    step();
    chk("t2_p3_de", de_o, 1);
    chk("t2_p3_data", do_o, 32'h23);
    chk("t2_p3_hs", hs_o, 0);
    got = 0; seen_done = 1'b0;
    s_valid = 1'b1;
    for (int s = 0; s < 60 && !seen_done; s++) begin
      if (s == 5) s_valid = 1'b0;
      step();
      if (de_o) begin
        chk("t2_data", do_o, 32'h24 + got);
        chk("t2_hs", hs_o, got == 1);
        chk("t2_vs", vs_o, 0);
        got++;
      end
      if (frame_done) seen_done = 1'b1;
    end
    chk("t2_count", got, 5);
    chk("t2_done_seen", seen_done, 1);

    // Height 0 holds IDLE while FIFO fills; then 8x1 frame under continuous upstream
    wdata = 12'h100; s_data = wdata; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t3_fill_ready", s_ready, i < 16);
      chk("t3_fill_no_de", de_o, 0);
      step();
    end
    chk("t3_accepted", wdata, 32'h110);
    chk("t3_full_ready", s_ready, 0);
    fw = 16'd8; fh = 16'd1; lb = 16'd0;
    step();
    chk("t3_start_no_de", de_o, 0);
    fh = 16'd0;
    for (int k = 0; k < 24; k++) begin
      step();
      expd = ((k % 3) == 0) && (k <= 21);
      chk("t3_de", de_o, expd);
      chk("t3_ready_rate", s_ready, expd);
      if (expd) begin
        chk("t3_data", do_o, 32'h100 + k / 3);
        chk("t3_hs", hs_o, k == 0);
        chk("t3_vs", vs_o, k == 0);
      end
      chk("t3_done", frame_done, k == 22);
    end
    s_valid = 1'b0;

    // Asynchronous reset after pixel 2 of a 4x2 frame
    fw = 16'd4; fh = 16'd2; lb = 16'd3;
    step();
    fh = 16'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_de", de_o, (k == 0) || (k == 3));
      if (k == 0) chk("t4_p1", do_o, 32'h108);
      if (k == 3) chk("t4_p2", do_o, 32'h109);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_de", de_o, 0);
    chk("t4_async_do", do_o, 0);
    chk("t4_async_hs", hs_o, 0);
    chk("t4_async_vs", vs_o, 0);
    chk("t4_async_done", frame_done, 0);
    chk("t4_async_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t4_ready_release", s_ready, 1);
    wdata = 12'h300; s_data = wdata; s_valid = 1'b1;
    repeat (3) step();
    s_valid = 1'b0;
    fw = 16'd3; fh = 16'd1; lb = 16'd0;
    step();
    fh = 16'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      expd = (k == 0) || (k == 3) || (k == 6);
      chk("t4_de", de_o, expd);
      if (expd) begin
        chk("t4_data", do_o, 32'h300 + k / 3);
        chk("t4_hs", hs_o, k == 0);
        chk("t4_vs", vs_o, k == 0);
      end
      chk("t4_done", frame_done, k == 7);
    end

    // Back-to-back instance: 3x2, no blanking
    chk("t5_ready", s_ready0, 1);
    s_valid0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data0 = 12'h51 + 12'(i);
      step();
    end
    s_valid0 = 1'b0;
    fh0 = 16'd2;
    step();
    fh0 = 16'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      expd = (k < 6);
      chk("t5_de", de0, expd);
      if (expd) begin
        chk("t5_data", do0, 32'h51 + k);
        chk("t5_hs", hs0, (k == 0) || (k == 3));
        chk("t5_vs", vs0, k == 0);
      end
      chk("t5_done", done0, k == 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
